// File: rtl/intr_controller.sv
// rtl/intr_controller.sv - memory-mapped 4-source interrupt controller
//
// Purpose:
//   Latches rising edges on four device request lines into pending bits.
//   Arbitrates among the enabled pending sources with fixed or rotating
//   priority. Runs the request / acknowledge / end-of-interrupt handshake so
//   that only one interrupt is in service at a time.
//
// Register map (byte addresses):
//   BASE+0  ICTRL  R/W  bit0 GIE, bit1 RR, bits[7:4] MASK
//   BASE+4  IPEND  R    PEND[3:0]; W: write-1-to-clear
//   BASE+8  IVEC   R    {ACTIVE, 0.., IRQ_ID}; W: any value = EOI
//
// Ports:
//   CLK     system clock, all state on posedge
//   RESET   asynchronous active-high reset
//   ABUS    address bus
//   DBUS    bidirectional data bus, driven only during reads of this block
//   WE      write enable for the current bus cycle
//   FLUSH   pipeline flush, deselects the block
//   IRQ_IN  device request levels, bit 0 = highest fixed priority
//   IACK    processor accept pulse for the presented interrupt
//   INTR    registered interrupt request to the processor
//   IRQ_ID  registered source ID of the presented/active interrupt

module intr_controller #(
    parameter int              BITS = 32,
    parameter logic [BITS-1:0] BASE = 32'hF0000800
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    input  logic            FLUSH,
    input  logic [3:0]      IRQ_IN,
    input  logic            IACK,
    output logic            INTR,
    output logic [1:0]      IRQ_ID
);

    localparam logic [BITS-1:0] ADDR_CTRL = BASE;
    localparam logic [BITS-1:0] ADDR_PEND = BASE + BITS'(4);
    localparam logic [BITS-1:0] ADDR_VEC  = BASE + BITS'(8);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SIGNAL  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q;
    logic        intr_q;
    logic [1:0]  irq_id_q;
    logic [1:0]  last_q;

    logic        gie_q,  gie_d;
    logic        rr_q,   rr_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  irq_prev_q;

    // ------------------------------------------------------------------
    // Address decode and bus strobes
    // ------------------------------------------------------------------
    logic sel_ctrl, sel_pend, sel_vec;
    logic wr_ctrl, wr_pend, wr_eoi;
    logic rd_en;

    assign sel_ctrl = (ABUS == ADDR_CTRL) && !FLUSH;
    assign sel_pend = (ABUS == ADDR_PEND) && !FLUSH;
    assign sel_vec  = (ABUS == ADDR_VEC)  && !FLUSH;

    assign wr_ctrl  = WE && sel_ctrl;
    assign wr_pend  = WE && sel_pend;
    assign wr_eoi   = WE && sel_vec;
    assign rd_en    = !WE && (sel_ctrl || sel_pend || sel_vec);

    // ------------------------------------------------------------------
    // Read path (combinational onto the shared bus)
    // ------------------------------------------------------------------
    logic [BITS-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        if (sel_ctrl) begin
            rd_data[0]   = gie_q;
            rd_data[1]   = rr_q;
            rd_data[7:4] = mask_q;
        end else if (sel_pend) begin
            rd_data[3:0] = pend_q;
        end else if (sel_vec) begin
            rd_data[BITS-1] = (state_q == SERVICE);
            rd_data[1:0]    = irq_id_q;
        end
    end

    assign DBUS = rd_en ? rd_data : {BITS{1'bz}};

    // Upper data bits are never written into any register.
    logic unused_dbus_hi;
    assign unused_dbus_hi = &{1'b0, DBUS[BITS-1:8], DBUS[3:2]};

    // ------------------------------------------------------------------
    // Control register
    // ------------------------------------------------------------------
    always_comb begin
        gie_d  = gie_q;
        rr_d   = rr_q;
        mask_d = mask_q;
        if (wr_ctrl) begin
            gie_d  = DBUS[0];
            rr_d   = DBUS[1];
            mask_d = DBUS[7:4];
        end
    end

    // ------------------------------------------------------------------
    // Pending capture
    // ------------------------------------------------------------------
    logic [3:0] rise;
    logic [3:0] w1c_bits;
    logic [3:0] ack_bits;
    logic       iack_take;

    assign rise      = IRQ_IN & ~irq_prev_q;
    assign w1c_bits  = wr_pend ? DBUS[3:0] : 4'b0000;
    assign iack_take = (state_q == SIGNAL) && IACK;
    assign ack_bits  = iack_take ? (4'b0001 << irq_id_q) : 4'b0000;

    // A new edge in the same cycle as a clear keeps the bit set, so no
    // request is ever lost to a racing software clear or acknowledge.
    assign pend_d = (pend_q & ~(w1c_bits | ack_bits)) | rise;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [3:0] cand;
    logic [1:0] search_start;
    logic [1:0] win_id;
    logic       win_found;
    logic [1:0] probe;

    assign cand         = gie_q ? (pend_q & mask_q) : 4'b0000;
    assign search_start = rr_q ? (last_q + 2'd1) : 2'd0;

    // Scan four slots from the start index; 2-bit arithmetic supplies the
    // wrap-around for rotating mode and degenerates to 0..3 in fixed mode.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        probe     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            probe = search_start + 2'(i);
            if (!win_found && cand[probe]) begin
                win_found = 1'b1;
                win_id    = probe;
            end
        end
    end

    // Withdraw the presented request when software removes its reason to
    // exist: global disable, source masked, or its pending bit cleared now.
    logic withdraw;
    assign withdraw = !gie_q || !mask_q[irq_id_q] || !pend_d[irq_id_q];

    // ------------------------------------------------------------------
    // Handshake FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            intr_q   <= 1'b0;
            irq_id_q <= 2'd0;
            last_q   <= 2'd3;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q  <= SIGNAL;
                        intr_q   <= 1'b1;
                        irq_id_q <= win_id;
                    end
                end
                SIGNAL: begin
                    // IRQ_ID is frozen here; acknowledge beats withdraw.
                    if (IACK) begin
                        state_q <= SERVICE;
                        intr_q  <= 1'b0;
                        last_q  <= irq_id_q;
                    end else if (withdraw) begin
                        state_q <= IDLE;
                        intr_q  <= 1'b0;
                    end
                end
                SERVICE: begin
                    intr_q <= 1'b0;
                    if (wr_eoi) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file and edge detector
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gie_q      <= 1'b0;
            rr_q       <= 1'b0;
            mask_q     <= 4'b0000;
            pend_q     <= 4'b0000;
            irq_prev_q <= 4'b0000;
        end else begin
            gie_q      <= gie_d;
            rr_q       <= rr_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            irq_prev_q <= IRQ_IN;
        end
    end

    assign INTR   = intr_q;
    assign IRQ_ID = irq_id_q;

endmodule

// File: tb/tb_intr_controller.sv
// tb/tb_intr_controller.sv - scoreboard bench for intr_controller
module tb_intr_controller;

    localparam logic [31:0] A_CTRL = 32'hF0000800;
    localparam logic [31:0] A_PEND = 32'hF0000804;
    localparam logic [31:0] A_VEC  = 32'hF0000808;
    localparam logic [31:0] A_NONE = 32'hF000080C;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] ABUS;
    wire  [31:0] DBUS;
    logic        WE;
    logic        FLUSH;
    logic [3:0]  IRQ_IN;
    logic        IACK;
    logic        INTR;
    logic [1:0]  IRQ_ID;

    logic        tb_drv;
    logic [31:0] tb_dat;

    assign DBUS = tb_drv ? tb_dat : 32'bz;

    intr_controller #(.BITS(32), .BASE(32'hF0000800)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ABUS   (ABUS),
        .DBUS   (DBUS),
        .WE     (WE),
        .FLUSH  (FLUSH),
        .IRQ_IN (IRQ_IN),
        .IACK   (IACK),
        .INTR   (INTR),
        .IRQ_ID (IRQ_ID)
    );

    always #5 CLK = ~CLK;

    // kind 0: {INTR, IRQ_ID}; kind 1: DBUS value
    int          exp_kind[$];
    logic [31:0] exp_val[$];
    string       exp_name[$];
    logic [1:0]  exp_irq[$];

    int vectors     = 0;
    int miscompares = 0;

    logic        intr_prev = 1'b0;
    int          m_kind;
    logic [31:0] m_val;
    logic [31:0] m_act;
    string       m_name;
    logic [1:0]  m_id;

    // Monitor: pops whatever the stimulus queued for this cycle, and checks
    // the ID of every newly presented interrupt against the expected order.
    always @(negedge CLK) begin
        while (exp_kind.size() > 0) begin
            m_kind = exp_kind.pop_front();
            m_val  = exp_val.pop_front();
            m_name = exp_name.pop_front();
            if (m_kind == 0) m_act = {29'b0, INTR, IRQ_ID};
            else             m_act = DBUS;
            vectors++;
            if (m_act !== m_val) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", m_name, m_act, m_val);
            end
        end
        if (INTR === 1'b1 && intr_prev !== 1'b1) begin
            vectors++;
            if (exp_irq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_intr: got INTR=1 IRQ_ID=%0d, expected no interrupt", IRQ_ID);
            end else begin
                m_id = exp_irq.pop_front();
                if (IRQ_ID !== m_id) begin
                    miscompares++;
                    $display("FAIL presented_id: got %0d, expected %0d", IRQ_ID, m_id);
                end
            end
        end
        intr_prev = INTR;
    end

    task automatic step();
        @(posedge CLK);
        #1;
        ABUS   = '0;
        WE     = 1'b0;
        FLUSH  = 1'b0;
        IACK   = 1'b0;
        tb_drv = 1'b0;
        tb_dat = '0;
    endtask

    task automatic exp_st(input logic i, input logic [1:0] id, input string n);
        exp_kind.push_back(0);
        exp_val.push_back({29'b0, i, id});
        exp_name.push_back(n);
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [31:0] v, input string n);
        ABUS = a;
        WE   = 1'b0;
        exp_kind.push_back(1);
        exp_val.push_back(v);
        exp_name.push_back(n);
    endtask

    // Bench drives a pattern; the block must stay off the bus so it reads back intact.
    task automatic exp_float(input logic [31:0] a, input logic fl, input logic we,
                             input logic [31:0] pat, input string n);
        ABUS   = a;
        FLUSH  = fl;
        WE     = we;
        tb_drv = 1'b1;
        tb_dat = pat;
        exp_kind.push_back(1);
        exp_val.push_back(pat);
        exp_name.push_back(n);
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ABUS   = a;
        WE     = 1'b1;
        tb_drv = 1'b1;
        tb_dat = d;
        step();
    endtask

    task automatic pulse(input logic [3:0] b);
        IRQ_IN = b;
        step();
        IRQ_IN = 4'b0000;
    endtask

    task automatic ack();
        IACK = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET  = 1'b1;
        ABUS   = '0;
        WE     = 1'b0;
        FLUSH  = 1'b0;
        IRQ_IN = 4'b0000;
        IACK   = 1'b0;
        tb_drv = 1'b0;
        tb_dat = '0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        exp_st(1'b0, 2'd0, "rst_state"); exp_rd(A_CTRL, 32'h0, "rst_ictrl"); step();
        exp_rd(A_PEND, 32'h0, "rst_ipend"); step();
        exp_rd(A_VEC, 32'h0, "rst_ivec"); step();
        RESET = 1'b0;
        step();

        // 1: basic dispatch of source 2
        wr(A_CTRL, 32'hF1);
        exp_rd(A_CTRL, 32'hF1, "t1_ictrl"); exp_st(1'b0, 2'd0, "t1_idle"); step();
        exp_irq.push_back(2'd2);
        pulse(4'b0100);
        exp_st(1'b0, 2'd0, "t1_latency"); exp_rd(A_PEND, 32'h4, "t1_pend"); step();
        exp_st(1'b1, 2'd2, "t1_signal"); exp_rd(A_VEC, 32'h2, "t1_ivec_sig"); ack();
        exp_st(1'b0, 2'd2, "t1_service"); exp_rd(A_VEC, 32'h80000002, "t1_ivec_act"); step();
        exp_rd(A_PEND, 32'h0, "t1_pend_clr"); step();
        wr(A_VEC, 32'h0);
        exp_rd(A_VEC, 32'h2, "t1_eoi"); exp_st(1'b0, 2'd2, "t1_idle2"); step();

        // 2: fixed priority, simultaneous edges on 1 and 3
        exp_irq.push_back(2'd1);
        exp_irq.push_back(2'd3);
        pulse(4'b1010);
        exp_rd(A_PEND, 32'hA, "t2_pend"); step();
        exp_st(1'b1, 2'd1, "t2_first"); ack();
        exp_st(1'b0, 2'd1, "t2_svc"); exp_rd(A_PEND, 32'h8, "t2_pend_left"); step();
        wr(A_VEC, 32'h0);
        exp_st(1'b0, 2'd1, "t2_after_eoi"); step();
        exp_st(1'b1, 2'd3, "t2_second"); ack();
        exp_rd(A_PEND, 32'h0, "t2_pend_empty"); exp_st(1'b0, 2'd3, "t2_svc2"); step();
        wr(A_VEC, 32'h0);
        exp_rd(A_VEC, 32'h3, "t2_ivec_idle"); step();

        // 3: rotating priority
        wr(A_CTRL, 32'hF3);
        exp_irq.push_back(2'd0); exp_irq.push_back(2'd1);
        exp_irq.push_back(2'd2); exp_irq.push_back(2'd3);
        exp_irq.push_back(2'd0); exp_irq.push_back(2'd2);
        exp_irq.push_back(2'd0);
        pulse(4'b1111);
        exp_rd(A_PEND, 32'hF, "t3_pend_all"); step();
        for (int i = 0; i < 4; i++) begin
            exp_st(1'b1, 2'(i), $sformatf("t3_rr_%0d", i)); ack();
            exp_rd(A_VEC, 32'h80000000 | 32'(i), $sformatf("t3_ivec_%0d", i)); step();
            wr(A_VEC, 32'h0);
            step();
        end
        pulse(4'b0101);
        step();
        exp_st(1'b1, 2'd0, "t3_p5_first"); ack();
        pulse(4'b0001);
        exp_rd(A_PEND, 32'h5, "t3_pend5"); step();
        wr(A_VEC, 32'h0);
        step();
        exp_st(1'b1, 2'd2, "t3_rr_after_last0"); ack();
        wr(A_VEC, 32'h0);
        step();
        exp_st(1'b1, 2'd0, "t3_rr_wrap"); ack();
        wr(A_VEC, 32'h0);
        step();

        // 4: withdraw by W1C, by mask, and set-vs-clear collision
        wr(A_CTRL, 32'hF1);
        exp_irq.push_back(2'd1);
        pulse(4'b0010);
        step();
        exp_st(1'b1, 2'd1, "t4_sig"); wr(A_PEND, 32'h2);
        exp_st(1'b0, 2'd1, "t4_w1c_withdraw"); exp_rd(A_PEND, 32'h0, "t4_pend0"); step();
        step();
        exp_st(1'b0, 2'd1, "t4_stay_idle"); step();
        exp_irq.push_back(2'd1);
        pulse(4'b0010);
        step();
        exp_st(1'b1, 2'd1, "t4_sig2"); wr(A_CTRL, 32'hD1);
        step();
        exp_st(1'b0, 2'd1, "t4_mask_withdraw"); exp_rd(A_PEND, 32'h2, "t4_pend_kept"); step();
        step();
        exp_st(1'b0, 2'd1, "t4_masked_idle"); step();
        wr(A_PEND, 32'h2);
        wr(A_CTRL, 32'hF0);
        pulse(4'b0001);
        exp_rd(A_PEND, 32'h1, "t4_pend_bit0"); step();
        IRQ_IN = 4'b0001;
        wr(A_PEND, 32'h1);
        IRQ_IN = 4'b0000;
        exp_rd(A_PEND, 32'h1, "t4_set_wins"); step();
        wr(A_PEND, 32'h1);
        exp_rd(A_PEND, 32'h0, "t4_w1c_alone"); step();

        // 5: bus rules and masked source
        FLUSH = 1'b1;
        wr(A_CTRL, 32'hF3);
        exp_rd(A_CTRL, 32'hF0, "t5_flush_write"); step();
        exp_float(A_NONE, 1'b0, 1'b0, 32'h5A5A5A5A, "t5_z_unselected");
        exp_float(A_CTRL, 1'b1, 1'b0, 32'h0000000F, "t5_z_flush");
        exp_float(A_CTRL, 1'b0, 1'b1, 32'h0000000E, "t5_z_write");
        exp_rd(A_CTRL, 32'h02, "t5_ictrl_written"); step();
        wr(A_CTRL, 32'hB1);
        exp_irq.push_back(2'd2);
        pulse(4'b0100);
        step();
        exp_st(1'b0, 2'd1, "t5_masked_no_intr"); exp_rd(A_PEND, 32'h4, "t5_masked_pend"); step();
        wr(A_CTRL, 32'hF1);
        exp_st(1'b0, 2'd1, "t5_unmask_latency"); step();
        exp_st(1'b1, 2'd2, "t5_unmasked"); ack();

        // 6: asynchronous reset during SERVICE
        pulse(4'b1000);
        exp_rd(A_PEND, 32'h8, "t6_pend_pre"); step();
        exp_rd(A_VEC, 32'h80000002, "t6_active"); step();
        RESET = 1'b1;
        exp_st(1'b0, 2'd0, "t6_async_state"); exp_rd(A_CTRL, 32'h0, "t6_async_ictrl"); step();
        exp_rd(A_PEND, 32'h0, "t6_pend_lost"); step();
        exp_rd(A_VEC, 32'h0, "t6_ivec"); step();
        RESET = 1'b0;
        step();
        wr(A_CTRL, 32'hF1);
        exp_rd(A_PEND, 32'h0, "t6_no_pend"); step();
        exp_st(1'b0, 2'd0, "t6_no_intr"); step();
        exp_irq.push_back(2'd3);
        pulse(4'b1000);
        step();
        exp_st(1'b1, 2'd3, "t6_fresh_edge"); ack();
        wr(A_VEC, 32'h0);
        step();

        vectors++;
        if (exp_irq.size() != 0) begin
            miscompares++;
            $display("FAIL irq_drain: got %0d outstanding interrupts, expected 0", exp_irq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
